hex_scan_ctrl: RTL and testbench

Time-multiplexed scan controller that shares one seven-segment decoder and one segment bus across NUM_DIGITS common-anode digits. It holds a tear-free shadow copy of the displayed value, cycles digit enables with a blanking interval between digits, and accepts new values through a single-entry update handshake applied only at frame boundaries. It sits between the counter datapaths and the board's segment/anode pins.

---
 rtl/hex_scan_pkg.sv | 20 ++
 rtl/hex_scan_ctrl_if.sv | 22 ++
 rtl/hex_scan_ctrl_seg7_decode.sv | 11 +
 rtl/hex_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_hex_scan_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/hex_scan_pkg.sv
// Shared types and the seven-segment glyph table for the multiplexed hex display scanner.
// Segment vectors are active-low, with bit 0 = segment a and bit 6 = segment g.
package hex_scan_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      SHOW  = 1'b1
   } scan_state_t;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   // Index 15 is deliberately a blank glyph; the anode is still driven for that digit.
   localparam logic [6:0] SEG_LUT [0:15] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0011000, 7'b0100111, 7'b0110011,
      7'b0011101, 7'b0010110, 7'b0000111, 7'b1111111
   };

endpackage

// File: rtl/hex_scan_ctrl_if.sv
// Update handshake and display pin bundle for hex_scan_ctrl.
// The master side (the datapath) offers values; the slave side (the controller) drives the pins.
interface hex_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      upd_valid;
   logic [4*NUM_DIGITS-1:0]   upd_value;
   logic                      upd_busy;
   logic [6:0]                hex;
   logic [NUM_DIGITS-1:0]     an;
   logic                      frame_start;

   modport master (
      output upd_valid, upd_value,
      input  upd_busy, hex, an, frame_start
   );

   modport slave (
      input  upd_valid, upd_value,
      output upd_busy, hex, an, frame_start
   );
endinterface

// File: rtl/hex_scan_ctrl_seg7_decode.sv
// Combinational nibble-to-segment decoder that is shared by every scanned digit.
module seg7_decode
   import hex_scan_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_LUT[i_nibble];

endmodule

// File: rtl/hex_scan_ctrl.sv
// Time-multiplexed seven-segment scanner: a tear-free shadow register, blanking between digits, and frame-aligned updates.
// Leading-zero suppression is enabled by defining HEX_SCAN_LZ_SUPPRESS_EN.
//
//   state | meaning
//   BLANK | all anodes off, segments off; lasts BLANK_CYCLES
//   SHOW  | anode r_idx on, segments = glyph of shadow nibble r_idx; lasts DWELL_CYCLES
module hex_scan_ctrl
   import hex_scan_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int DWELL_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input logic          clk,
   input logic          rst,
   hex_scan_ctrl_if.slave bus
);

   localparam int MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int TW      = $clog2(MAX_CYC + 1);
   localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DW      = 4 * NUM_DIGITS;

   localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);
   localparam logic [TW-1:0] SHOW_LAST  = TW'(DWELL_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   scan_state_t            r_state;
   logic [TW-1:0]          r_timer;
   logic [IW-1:0]          r_idx;
   logic [DW-1:0]          r_shadow;
   logic [DW-1:0]          r_staging;
   logic                   r_pending;
   logic [NUM_DIGITS-1:0]  r_an;
   logic [6:0]             r_hex;
   logic                   r_frame_start;

   logic [3:0]             w_nibble;
   logic [6:0]             w_seg;
   logic                   w_dark;
   logic [NUM_DIGITS-1:0]  w_an_lit;

   always_comb begin
      w_nibble = 4'h0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_nibble = r_shadow[4*i +: 4];
         end
      end
   end

   seg7_decode u_dec (
      .i_nibble (w_nibble),
      .o_seg    (w_seg)
   );

`ifdef HEX_SCAN_LZ_SUPPRESS_EN
   // A digit is a leading zero when it and every higher nibble are zero; digit 0 always stays lit.
   always_comb begin
      w_dark = 1'b0;
      if (r_idx != '0) begin
         w_dark = 1'b1;
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if ((IW'(i) >= r_idx) && (r_shadow[4*i +: 4] != 4'h0)) begin
               w_dark = 1'b0;
            end
         end
      end
   end
`else
   assign w_dark = 1'b0;
`endif

   assign w_an_lit = ~(NUM_DIGITS'(1) << r_idx);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= BLANK;
         r_timer       <= '0;
         r_idx         <= '0;
         r_shadow      <= '0;
         r_staging     <= '0;
         r_pending     <= 1'b0;
         r_an          <= '1;
         r_hex         <= SEG_OFF;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= 1'b0;

         if (bus.upd_valid && !r_pending) begin
            r_staging <= bus.upd_value;
            r_pending <= 1'b1;
         end

         case (r_state)
            BLANK: begin
               if (r_timer == BLANK_LAST) begin
                  r_state       <= SHOW;
                  r_timer       <= '0;
                  r_an          <= w_dark ? '1 : w_an_lit;
                  r_hex         <= w_dark ? SEG_OFF : w_seg;
                  r_frame_start <= (r_idx == '0);
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            SHOW: begin
               if (r_timer == SHOW_LAST) begin
                  r_state <= BLANK;
                  r_timer <= '0;
                  r_an    <= '1;
                  r_hex   <= SEG_OFF;
                  if (r_idx == IDX_LAST) begin
                     r_idx <= '0;
                     // Frame boundary: the only point where the shadow copy is allowed to change.
                     if (r_pending) begin
                        r_shadow  <= r_staging;
                        r_pending <= 1'b0;
                     end
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            default: begin
               r_state <= BLANK;
               r_timer <= '0;
            end
         endcase
      end
   end

   assign bus.upd_busy    = r_pending;
   assign bus.hex         = r_hex;
   assign bus.an          = r_an;
   assign bus.frame_start = r_frame_start;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed and random checks of hex_scan_ctrl against a frame-position reference model.
module tb_hex_scan_ctrl;

   localparam int ND    = 4;
   localparam int DWELL = 4;
   localparam int BLNK  = 2;
   localparam int SLOT  = DWELL + BLNK;
   localparam int FRAME = ND * SLOT;

   logic clk;
   logic rst;

   hex_scan_ctrl_if #(.NUM_DIGITS(ND)) bus_if ();

   hex_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .DWELL_CYCLES (DWELL),
      .BLANK_CYCLES (BLNK)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] glyph [0:15];
   initial begin
      glyph[0]  = 7'b1000000; glyph[1]  = 7'b1111001; glyph[2]  = 7'b0100100; glyph[3]  = 7'b0110000;
      glyph[4]  = 7'b0011001; glyph[5]  = 7'b0010010; glyph[6]  = 7'b0000010; glyph[7]  = 7'b1111000;
      glyph[8]  = 7'b0000000; glyph[9]  = 7'b0011000; glyph[10] = 7'b0100111; glyph[11] = 7'b0110011;
      glyph[12] = 7'b0011101; glyph[13] = 7'b0010110; glyph[14] = 7'b0000111; glyph[15] = 7'b1111111;
   end

   int n_cmp = 0;
   int n_err = 0;

   // Model: t counts edges since reset release; the display is a pure function of t and the shadow value.
   int          m_t;
   logic [15:0] m_shadow;
   logic [15:0] m_stage;
   logic        m_pend;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s t=%0d observed=%h expected=%h", tag, m_t, obs, exp);
      end
   endtask

   task automatic check_outputs();
      int q, slot, w;
      logic dark;
      logic [3:0] an_e;
      logic [6:0] hex_e;
      logic fs_e;
      logic [3:0] nib;
      q    = m_t % FRAME;
      slot = q / SLOT;
      w    = q % SLOT;
      nib  = 4'((m_shadow >> (4 * slot)) & 16'hF);
`ifdef HEX_SCAN_LZ_SUPPRESS_EN
      dark = (slot > 0) && ((m_shadow >> (4 * slot)) == 16'h0);
`else
      dark = 1'b0;
`endif
      if (w < BLNK || dark) begin
         an_e  = 4'b1111;
         hex_e = 7'b1111111;
      end else begin
         an_e  = ~(4'b0001 << slot);
         hex_e = glyph[nib];
      end
      fs_e = (slot == 0) && (w == BLNK);
      chk("an", 32'(bus_if.an), 32'(an_e));
      chk("hex", 32'(bus_if.hex), 32'(hex_e));
      chk("frame_start", 32'(bus_if.frame_start), 32'(fs_e));
      chk("upd_busy", 32'(bus_if.upd_busy), 32'(m_pend));
   endtask

   task automatic tick(input logic v, input logic [15:0] val);
      bus_if.upd_valid = v;
      bus_if.upd_value = val;
      @(posedge clk);
      if (v && !m_pend) begin
         m_stage = val;
         m_pend  = 1'b1;
      end else if (((m_t + 1) % FRAME == 0) && m_pend) begin
         m_shadow = m_stage;
         m_pend   = 1'b0;
      end
      m_t = m_t + 1;
      @(negedge clk);
      bus_if.upd_valid = 1'b0;
      check_outputs();
   endtask

   task automatic run_to(input int q);
      for (int k = 0; k < FRAME; k++) begin
         if (m_t % FRAME == q) break;
         tick(1'b0, 16'h0);
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_an"}, 32'(bus_if.an), 32'h0000000F);
      chk({tag, "_hex"}, 32'(bus_if.hex), 32'h0000007F);
      chk({tag, "_busy"}, 32'(bus_if.upd_busy), 32'h0);
      chk({tag, "_fs"}, 32'(bus_if.frame_start), 32'h0);
   endtask

   task automatic model_reset();
      m_t      = 0;
      m_shadow = 16'h0;
      m_stage  = 16'h0;
      m_pend   = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus_if.upd_valid = 1'b0;
      bus_if.upd_value = 16'h0;
      model_reset();
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      rst = 1'b0;

      // Reset release and first frame, including the first lit digit and the frame_start pulse
      repeat (26) tick(1'b0, 16'h0);

      // Plain update applied at the next boundary
      run_to(5);
      tick(1'b1, 16'h1234);
      repeat (50) tick(1'b0, 16'h0);

      // Update mid-frame, then a second request while busy, which must be ignored
      run_to(9);
      tick(1'b1, 16'h5678);
      tick(1'b1, 16'h9999);
      tick(1'b1, 16'h9999);
      repeat (50) tick(1'b0, 16'h0);

      // Request on the boundary edge itself lands at the following boundary
      run_to(FRAME - 1);
      tick(1'b1, 16'hFA00);
      repeat (55) tick(1'b0, 16'h0);

      // Random traffic
      for (int k = 0; k < 160; k++) begin
         tick(($urandom % 6) == 0, 16'($urandom));
      end

      // Asynchronous reset in the SHOW slot of digit 2 while an update is pending
      run_to(12);
      tick(1'b1, 16'h4321);
      run_to(15);
      #1 rst = 1'b1;
      #1;
      check_reset_values("async_rst");
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_values("rst_hold");
      rst = 1'b0;
      repeat (30) tick(1'b0, 16'h0);

      // Values with leading zeros
      tick(1'b1, 16'h0005);
      repeat (50) tick(1'b0, 16'h0);
      tick(1'b1, 16'h0000);
      repeat (50) tick(1'b0, 16'h0);
      tick(1'b1, 16'h0F00);
      repeat (50) tick(1'b0, 16'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
